// File: rtl/motoro3_sixstep_pwm.sv
// Six-step (trapezoidal) BLDC commutation sequencer with dead time between steps
// and a soft start that walks the step period toward the requested value.
module motoro3_sixstep_pwm #(
    parameter int unsigned FREQ_W    = 10,
    parameter int unsigned PRE_DIV   = 50,
    parameter int unsigned DEAD_CYC  = 4,
    parameter int unsigned START_PER = 1023
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              m3start,
    input  logic              m3invOrStop,
    input  logic [FREQ_W-1:0] m3freq,
    output logic              aH,
    output logic              aL,
    output logic              bH,
    output logic              bL,
    output logic              cH,
    output logic              cL,
    output logic [2:0]        step,
    output logic              running
);

    localparam int unsigned PreW  = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int unsigned DeadW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [PreW-1:0]   PreLast  = PreW'(PRE_DIV - 1);
    localparam logic [DeadW-1:0]  DeadLast = DeadW'(DEAD_CYC - 1);
    localparam logic [FREQ_W-1:0] StartPer = FREQ_W'(START_PER);

    typedef enum logic [1:0] {
        StIdle,
        StDead,
        StDrive
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic              dir_q, dir_d;
    logic [FREQ_W-1:0] cur_per_q, cur_per_d;
    logic [PreW-1:0]   pre_q, pre_d;
    logic [FREQ_W-1:0] tmr_q, tmr_d;
    logic [DeadW-1:0]  dead_q, dead_d;
    logic              inv_q;
    logic [5:0]        gates_q, gates_d;
    logic              running_q, running_d;

    logic inv_rise;
    logic tick;
    logic boundary;

    // Gate vector order: {aH, aL, bH, bL, cH, cL}
    function automatic logic [5:0] gate_pattern(input logic [2:0] s);
        logic [5:0] g;
        case (s)
            3'd0:    g = 6'b100100;
            3'd1:    g = 6'b100001;
            3'd2:    g = 6'b001001;
            3'd3:    g = 6'b011000;
            3'd4:    g = 6'b010010;
            3'd5:    g = 6'b000110;
            default: g = 6'b000000;
        endcase
        return g;
    endfunction

    function automatic logic [2:0] next_step(input logic [2:0] s, input logic reverse);
        logic [2:0] n;
        if (!reverse) begin
            n = (s >= 3'd5) ? 3'd0 : s + 3'd1;
        end else begin
            n = (s == 3'd0) ? 3'd5 : s - 3'd1;
        end
        return n;
    endfunction

    assign inv_rise = m3invOrStop & ~inv_q;
    assign tick     = (state_q == StDrive) && (pre_q == PreLast);
    assign boundary = tick && (tmr_q == cur_per_q - FREQ_W'(1));

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        dir_d     = dir_q;
        cur_per_d = cur_per_q;
        pre_d     = pre_q;
        tmr_d     = tmr_q;
        dead_d    = dead_q;

        case (state_q)
            StIdle: begin
                pre_d  = '0;
                tmr_d  = '0;
                dead_d = '0;
                if (m3start && (m3freq != '0)) begin
                    state_d   = StDead;
                    step_d    = 3'd0;
                    dir_d     = m3invOrStop;
                    cur_per_d = (m3freq > StartPer) ? m3freq : StartPer;
                end
            end
            StDead: begin
                if (inv_rise) begin
                    state_d = StIdle;
                    pre_d   = '0;
                    tmr_d   = '0;
                    dead_d  = '0;
                end else if (dead_q == DeadLast) begin
                    state_d = StDrive;
                    dead_d  = '0;
                end else begin
                    dead_d = dead_q + DeadW'(1);
                end
            end
            StDrive: begin
                if (inv_rise) begin
                    // Stop request wins over a coincident step boundary
                    state_d = StIdle;
                    pre_d   = '0;
                    tmr_d   = '0;
                end else begin
                    pre_d = tick ? '0 : pre_q + PreW'(1);
                    if (boundary) begin
                        tmr_d = '0;
                        if (m3freq == '0) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StDead;
                            step_d  = next_step(step_q, dir_q);
                            if (cur_per_q > m3freq) begin
                                cur_per_d = cur_per_q - FREQ_W'(1);
                            end else if (cur_per_q < m3freq) begin
                                cur_per_d = cur_per_q + FREQ_W'(1);
                            end
                        end
                    end else if (tick) begin
                        tmr_d = tmr_q + FREQ_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                pre_d   = '0;
                tmr_d   = '0;
                dead_d  = '0;
            end
        endcase

        // Outputs are registered from next state so they line up with state_q
        gates_d   = (state_d == StDrive) ? gate_pattern(step_d) : 6'b000000;
        running_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q   <= StIdle;
            step_q    <= 3'd0;
            dir_q     <= 1'b0;
            cur_per_q <= StartPer;
            pre_q     <= '0;
            tmr_q     <= '0;
            dead_q    <= '0;
            inv_q     <= 1'b1;
            gates_q   <= 6'b000000;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            cur_per_q <= cur_per_d;
            pre_q     <= pre_d;
            tmr_q     <= tmr_d;
            dead_q    <= dead_d;
            inv_q     <= m3invOrStop;
            gates_q   <= gates_d;
            running_q <= running_d;
        end
    end

    assign {aH, aL, bH, bL, cH, cL} = gates_q;
    assign step    = step_q;
    assign running = running_q;

endmodule

// File: tb/tb_motoro3_sixstep_pwm.sv
// Scoreboard bench: stimulus queues expected output segments (pattern, step, running, length);
// a negedge monitor pops one per observed output change and also checks gate safety.
module tb_motoro3_sixstep_pwm;

    localparam int unsigned FREQ_W    = 4;
    localparam int unsigned PRE_DIV   = 2;
    localparam int unsigned DEAD_CYC  = 2;
    localparam int unsigned START_PER = 8;

    logic              clk = 1'b0;
    logic              nRst;
    logic              m3start;
    logic              m3invOrStop;
    logic [FREQ_W-1:0] m3freq;
    logic              aH, aL, bH, bL, cH, cL;
    logic [2:0]        step;
    logic              running;
    logic [5:0]        gates;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [5:0] g;
        logic [2:0] s;
        logic       r;
        int         len;
    } exp_t;

    exp_t sb[$];

    motoro3_sixstep_pwm #(
        .FREQ_W   (FREQ_W),
        .PRE_DIV  (PRE_DIV),
        .DEAD_CYC (DEAD_CYC),
        .START_PER(START_PER)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .m3start    (m3start),
        .m3invOrStop(m3invOrStop),
        .m3freq     (m3freq),
        .aH         (aH),
        .aL         (aL),
        .bH         (bH),
        .bL         (bL),
        .cH         (cH),
        .cL         (cL),
        .step       (step),
        .running    (running)
    );

    always #5 clk = ~clk;

    assign gates = {aH, aL, bH, bL, cH, cL};

    // Expected drive patterns, {aH, aL, bH, bL, cH, cL}
    function automatic logic [5:0] pat(input int s);
        logic [5:0] g;
        case (s)
            0:       g = 6'b100100;
            1:       g = 6'b100001;
            2:       g = 6'b001001;
            3:       g = 6'b011000;
            4:       g = 6'b010010;
            5:       g = 6'b000110;
            default: g = 6'b000000;
        endcase
        return g;
    endfunction

    task automatic push(input logic [5:0] g, input int s, input logic r, input int len);
        exp_t e;
        e.g   = g;
        e.s   = 3'(s);
        e.r   = r;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int len);
        push(6'b000000, 0, 1'b0, len);
    endtask

    // One commutation step: dead segment then drive segment
    task automatic push_step(input int s, input int drive_len);
        push(6'b000000, s, 1'b1, DEAD_CYC);
        push(pat(s), s, 1'b1, drive_len);
    endtask

    // ---------------- monitor ----------------
    bit         mon_en = 1'b0;
    bit         started = 1'b0;
    logic [9:0] obs_key;
    logic [9:0] cur_key;
    int         cur_len;
    int         seg_cnt;
    int         seg_idx = 0;
    logic [5:0] last_pat;
    bit         have_last = 1'b0;
    int         off_run = 0;
    exp_t       e_pop;

    always @(negedge clk) begin
        if (mon_en) begin
            obs_key = {gates, (running ? step : 3'd0), running};

            tests++;
            if ((aH && aL) || (bH && bL) || (cH && cL)) begin
                fails++;
                $display("FAIL shoot_through t=%0t gates=%b required no phase with H&L", $time,
                         gates);
            end

            if (gates != 6'b000000) begin
                if (have_last && (gates != last_pat)) begin
                    tests++;
                    if (off_run < DEAD_CYC) begin
                        fails++;
                        $display("FAIL dead_time t=%0t off_cycles=%0d required >=%0d", $time,
                                 off_run, DEAD_CYC);
                    end
                end
                last_pat  = gates;
                have_last = 1'b1;
                off_run   = 0;
            end else begin
                off_run++;
            end

            if (!started || (obs_key != cur_key)) begin
                if (started && (cur_len >= 0)) begin
                    tests++;
                    if (seg_cnt != cur_len) begin
                        fails++;
                        $display("FAIL seg_len[%0d] got %0d cycles required %0d", seg_idx - 1,
                                 seg_cnt, cur_len);
                    end
                end
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_seg[%0d] got key=%b required none", seg_idx,
                             obs_key);
                    cur_len = -1;
                end else begin
                    e_pop = sb.pop_front();
                    if (obs_key != {e_pop.g, e_pop.s, e_pop.r}) begin
                        fails++;
                        $display("FAIL seg[%0d] got g=%b s=%0d r=%b required g=%b s=%0d r=%b",
                                 seg_idx, obs_key[9:4], obs_key[3:1], obs_key[0], e_pop.g,
                                 e_pop.s, e_pop.r);
                    end
                    cur_len = e_pop.len;
                end
                cur_key = obs_key;
                seg_cnt = 1;
                seg_idx++;
                started = 1'b1;
            end else begin
                seg_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_drive(input int s, input string name);
        int  n = 0;
        bit  hit = 1'b0;
        do begin
            @(negedge clk);
            n++;
            hit = (gates == pat(s)) && (step == 3'(s)) && running;
        end while (!hit && n < 500);
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL %s timeout got gates=%b step=%0d required gates=%b step=%0d", name,
                     gates, step, pat(s), s);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        bit hit = 1'b0;
        do begin
            @(negedge clk);
            n++;
            hit = !running && (gates == 6'b000000);
        end while (!hit && n < 500);
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL %s timeout got running=%b gates=%b required 0/000000", name, running,
                     gates);
        end
    endtask

    task automatic hold_reset(input int cycles);
        nRst = 1'b0;
        repeat (cycles) @(negedge clk);
        nRst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nRst        = 1'b0;
        m3start     = 1'b0;
        m3invOrStop = 1'b0;
        m3freq      = '0;
        repeat (3) @(negedge clk);
        nRst   = 1'b1;
        mon_en = 1'b1;

        // Forward soft start from 8 down to 5, then stop via m3freq=0
        push_idle(-1);
        push_step(0, 16);
        push_step(1, 14);
        push_step(2, 12);
        push_step(3, 10);
        push_step(4, 10);
        push_step(5, 10);
        push_idle(-1);
        @(negedge clk);
        m3freq  = 4'd5;
        m3start = 1'b1;
        @(negedge clk);
        m3start = 1'b0;
        wait_drive(5, "fwd_step5");
        m3freq = '0;
        wait_idle("fwd_stop");

        // Reverse at period 8: 0,5,4,3,2,1,0
        hold_reset(2);
        m3invOrStop = 1'b1;
        m3freq      = 4'd8;
        push_step(0, 16);
        push_step(5, 16);
        push_step(4, 16);
        push_step(3, 16);
        push_step(2, 16);
        push_step(1, 16);
        push_step(0, 16);
        push_idle(-1);
        @(negedge clk);
        m3start = 1'b1;
        @(negedge clk);
        m3start = 1'b0;
        wait_drive(1, "rev_step1");
        wait_drive(0, "rev_step0_again");
        m3freq = '0;
        wait_idle("rev_stop");

        // Stop edge mid-drive with start held, restart reversed, reset pulse in step 3
        m3invOrStop = 1'b0;
        m3freq      = 4'd8;
        hold_reset(2);
        push_step(0, 6);
        push_idle(1);
        push_step(0, 16);
        push_step(5, 16);
        push_step(4, 16);
        push_step(3, 4);
        push_idle(1);
        push_step(0, 16);
        push_idle(-1);
        @(negedge clk);
        m3start = 1'b1;
        wait_drive(0, "edge_step0");
        repeat (5) @(negedge clk);
        m3invOrStop = 1'b1;
        wait_drive(3, "restart_step3");
        repeat (3) @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        tests++;
        if ((step != 3'd0) || running) begin
            fails++;
            $display("FAIL reset_mid_drive got step=%0d running=%b required 0/0", step, running);
        end
        nRst = 1'b1;
        wait_drive(0, "post_reset_step0");
        m3start = 1'b0;
        m3freq  = '0;
        wait_idle("final_stop");

        repeat (10) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
